// File: rtl/imem_line_responder_if.sv
// Line-fill bus between the I-cache miss path (master) and the memory-side
// responder (slave), plus the preload port used by the program loader.
//
// Handshake: the master raises IREQ with a line address on IADDR and the slave
// accepts it on any posedge where it is idle. IREQ is level-sensitive but is
// only sampled while idle. busy is high from the accept edge through the
// response cycle. mem_ready is a one-cycle pulse meaning "data_out holds the
// requested line". There is no back-pressure. load_en writes are honoured only
// while the responder is idle.
interface imem_line_responder_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  IREQ;
  logic [31:0]           IADDR;
  logic [127:0]          data_out;
  logic                  mem_ready;
  logic                  busy;
  logic                  load_en;
  logic [DEPTH_LOG2-1:0] load_addr;
  logic [31:0]           load_data;

  modport master (
    output IREQ, IADDR, load_en, load_addr, load_data,
    input  data_out, mem_ready, busy
  );

  modport slave (
    input  IREQ, IADDR, load_en, load_addr, load_data,
    output data_out, mem_ready, busy
  );
endinterface

// File: rtl/imem_line_responder.sv
// Main-memory side of the I-cache line fill. A request is accepted, delayed by
// LATENCY cycles, read beat by beat into a shadow buffer, and then published
// as a complete 128-bit line together with a one-cycle mem_ready pulse.
module imem_line_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  imem_line_responder_if.slave        bus,
  output logic [1:0]                  dbg_state_o
);

  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [7:0] LAT_INIT = 8'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic [1:0]            beat_q;
  logic [DEPTH_LOG2-3:0] line_q;
  logic [31:0]           shadow_q [4];
  logic [127:0]          data_out_q;
  logic                  mem_ready_q;
  logic                  busy_q;
  logic [31:0]           mem_q [WORDS];

  logic [DEPTH_LOG2-3:0] line_d;
  logic [DEPTH_LOG2-1:0] rd_idx_d;
  logic [31:0]           rd_word_d;
  logic                  unused_addr_bits;

  // Line index of the incoming request; upper bits alias, low nibble is the
  // byte/word offset inside the line and is dropped.
  assign line_d           = bus.IADDR[DEPTH_LOG2+1:4];
  assign unused_addr_bits = ^{bus.IADDR[31:DEPTH_LOG2+2], bus.IADDR[3:0]};

  // Beat n always stays inside the latched line: the beat is the low word index.
  assign rd_idx_d  = {line_q, beat_q};
  assign rd_word_d = mem_q[rd_idx_d];

  // Preload port: writes only land while idle so an in-flight fill sees a
  // stable line. The array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_IDLE) && bus.load_en) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  // Request FSM with registered outputs: IDLE -> WAIT -> FILL -> RESP -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      line_q      <= '0;
      shadow_q    <= '{default: '0};
      data_out_q  <= '0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.IREQ) begin
            line_q  <= line_d;
            cnt_q   <= LAT_INIT;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            beat_q  <= 2'd0;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          shadow_q[beat_q] <= rd_word_d;
          beat_q           <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            // Lane 3 is taken straight from the read port so the published
            // line is complete in the same edge that fills the last lane.
            data_out_q  <= {rd_word_d, shadow_q[2], shadow_q[1], shadow_q[0]};
            mem_ready_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.busy      = busy_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: one instance with LATENCY=4 and one
// with LATENCY=1, both sharing the same preload sequence.
module tb_imem_line_responder;

  localparam logic [127:0] LINE_A    = 128'hA0000007_A0000006_A0000005_A0000004;
  localparam logic [127:0] LINE_B    = 128'hB000000B_B000000A_B0000009_B0000008;
  localparam logic [127:0] LINE_A_DB = 128'hA0000007_A0000006_DEADBEEF_A0000004;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_a;
  logic [1:0] state_b;
  int         checks;
  int         errors;

  imem_line_responder_if #(.DEPTH_LOG2(10)) bus_a ();
  imem_line_responder_if #(.DEPTH_LOG2(10)) bus_b ();

  imem_line_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_a),
    .dbg_state_o (state_a)
  );

  imem_line_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_b),
    .dbg_state_o (state_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux so one request task can serve either instance.
  logic         use_b;
  logic         m_ready;
  logic         m_busy;
  logic [127:0] m_data;
  always_comb begin
    m_ready = use_b ? bus_b.mem_ready : bus_a.mem_ready;
    m_busy  = use_b ? bus_b.busy      : bus_a.busy;
    m_data  = use_b ? bus_b.data_out  : bus_a.data_out;
  end

  // Advance one edge and land 1 ns after it for driving and sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Preload one word into both instances while they are idle.
  task automatic load_word(input logic [9:0] addr, input logic [31:0] data);
    bus_a.load_en = 1'b1; bus_a.load_addr = addr; bus_a.load_data = data;
    bus_b.load_en = 1'b1; bus_b.load_addr = addr; bus_b.load_data = data;
    tick();
    bus_a.load_en = 1'b0;
    bus_b.load_en = 1'b0;
  endtask

  // Single request: IREQ high for the accept edge only, then watch 16 edges.
  // Optional load on the accept edge (idle_load) or on the first WAIT edge.
  task automatic run_req(input string tag, input logic sel_b, input logic [31:0] addr,
                         input int exp_ready, input int exp_busy, input logic [127:0] exp_line,
                         input logic idle_load, input logic wait_load);
    int           ready_at;
    int           pulses;
    int           busy_n;
    logic [127:0] data_seen;
    use_b = sel_b;
    ready_at = -1; pulses = 0; busy_n = 0; data_seen = '0;
    if (sel_b) begin bus_b.IREQ = 1'b1; bus_b.IADDR = addr; end
    else begin bus_a.IREQ = 1'b1; bus_a.IADDR = addr; end
    if (idle_load) begin
      bus_a.load_en = 1'b1; bus_a.load_addr = 10'd5; bus_a.load_data = 32'hDEADBEEF;
    end
    tick();
    bus_a.IREQ = 1'b0; bus_b.IREQ = 1'b0; bus_a.load_en = 1'b0;
    if (m_busy === 1'b1) busy_n++;
    for (int k = 1; k <= 16; k++) begin
      if (wait_load && k == 1) begin
        bus_a.load_en = 1'b1; bus_a.load_addr = 10'd5; bus_a.load_data = 32'hDEADBEEF;
      end
      tick();
      bus_a.load_en = 1'b0;
      if (m_busy === 1'b1) busy_n++;
      if (m_ready === 1'b1) begin
        pulses++;
        if (ready_at < 0) begin
          ready_at  = k;
          data_seen = m_data;
        end
      end
    end
    chk({tag, "_ready_edge"}, 128'(ready_at), 128'(exp_ready));
    chk({tag, "_pulses"},     128'(pulses),   128'd1);
    chk({tag, "_busy_cycles"}, 128'(busy_n),  128'(exp_busy));
    chk({tag, "_line"},       data_seen,      exp_line);
    chk({tag, "_held"},       m_data,         exp_line);
  endtask

  // Directed sequence
  initial begin
    int           first_at;
    int           second_at;
    int           pulses;
    logic         stable_ok;
    checks = 0; errors = 0; use_b = 1'b0;
    rst_n = 1'b0;
    bus_a.IREQ = 1'b0; bus_a.IADDR = '0; bus_a.load_en = 1'b0; bus_a.load_addr = '0; bus_a.load_data = '0;
    bus_b.IREQ = 1'b0; bus_b.IADDR = '0; bus_b.load_en = 1'b0; bus_b.load_addr = '0; bus_b.load_data = '0;
    tick();
    tick();
    chk("rst_busy",  128'(bus_a.busy),      128'd0);
    chk("rst_ready", 128'(bus_a.mem_ready), 128'd0);
    chk("rst_data",  bus_a.data_out,        128'd0);
    chk("rst_state", 128'(state_a),         128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 4; i < 8; i++)  load_word(10'(i), 32'hA0000000 + 32'(i));
    for (int i = 8; i < 12; i++) load_word(10'(i), 32'hB0000000 + 32'(i));

    // Basic fill, offset alignment and aliasing all return line 4..7.
    run_req("basic", 1'b0, 32'h0000_0010, 8, 9, LINE_A, 1'b0, 1'b0);
    run_req("offset", 1'b0, 32'h0000_001C, 8, 9, LINE_A, 1'b0, 1'b0);
    run_req("alias", 1'b0, 32'h0000_1010, 8, 9, LINE_A, 1'b0, 1'b0);

    // Back-to-back: IREQ held, address switched at the first ready pulse.
    use_b = 1'b0;
    first_at = -1; second_at = -1; pulses = 0; stable_ok = 1'b1;
    bus_a.IREQ = 1'b1; bus_a.IADDR = 32'h10;
    tick();
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (first_at >= 0 && second_at < 0 && bus_a.mem_ready !== 1'b1 && bus_a.data_out !== LINE_A)
        stable_ok = 1'b0;
      if (bus_a.mem_ready === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = k;
          chk("b2b_first_line", bus_a.data_out, LINE_A);
          bus_a.IADDR = 32'h20;
        end else if (second_at < 0) begin
          second_at = k;
          chk("b2b_second_line", bus_a.data_out, LINE_B);
          bus_a.IREQ = 1'b0;
        end
      end
    end
    bus_a.IREQ = 1'b0;
    chk("b2b_first_edge",  128'(first_at),  128'd8);
    chk("b2b_second_edge", 128'(second_at), 128'd18);
    chk("b2b_pulses",      128'(pulses),    128'd2);
    chk("b2b_stable",      128'(stable_ok), 128'd1);
    chk("b2b_idle_busy",   128'(bus_a.busy), 128'd0);

    // Load gating: ignored during WAIT, honoured alongside an IDLE accept.
    run_req("wait_load", 1'b0, 32'h10, 8, 9, LINE_A, 1'b0, 1'b1);
    run_req("idle_load", 1'b0, 32'h10, 8, 9, LINE_A_DB, 1'b1, 1'b0);
    load_word(10'd5, 32'hA0000005);

    // Reset during beat 2 of FILL.
    bus_a.IREQ = 1'b1; bus_a.IADDR = 32'h10;
    tick();
    bus_a.IREQ = 1'b0;
    repeat (6) tick();
    chk("rst_fill_state_before", 128'(state_a), 128'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_fill_busy",  128'(bus_a.busy),      128'd0);
    chk("rst_fill_ready", 128'(bus_a.mem_ready), 128'd0);
    chk("rst_fill_data",  bus_a.data_out,        128'd0);
    chk("rst_fill_state", 128'(state_a),         128'd0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus_a.mem_ready === 1'b1) pulses++;
    end
    chk("rst_fill_no_pulse", 128'(pulses), 128'd0);
    run_req("after_rst", 1'b0, 32'h10, 8, 9, LINE_A, 1'b0, 1'b0);

    // IREQ for one cycle on the LATENCY=1 instance.
    run_req("lat1_drop", 1'b1, 32'h10, 5, 6, LINE_A, 1'b0, 1'b0);
    chk("lat1_idle_state", 128'(state_b), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
